instr_fetch_ir: RTL

Instruction fetch/assembly stage sitting directly upstream of the program counter in the RISC CPU. Accepts the 8-bit instruction stream read from program memory, assembles byte pairs into 16-bit instructions, buffers up to two complete instructions, and hands opcode plus 13-bit target address to the controller and PC. Generates the per-byte `inc_pc` advance pulse and discards in-flight fetch state on a jump flush.

---
 rtl/instr_fetch_ir_if.sv | 25 ++
 rtl/instr_fetch_ir.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_ir_if.sv
// rtl/instr_fetch_ir_if.sv - byte stream, flush and instruction queue handshake bundle for instr_fetch_ir
interface instr_fetch_ir_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic        inc_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [12:0] addr_ir;
  logic        halt;

  // Environment side: program memory, controller and PC.
  modport master (
    output byte_in, byte_valid, flush, instr_ready,
    input  byte_ready, inc_pc, instr_valid, opcode, addr_ir, halt
  );

  // Fetch stage side.
  modport slave (
    input  byte_in, byte_valid, flush, instr_ready,
    output byte_ready, inc_pc, instr_valid, opcode, addr_ir, halt
  );
endinterface

// File: rtl/instr_fetch_ir.sv
// rtl/instr_fetch_ir.sv - byte-pair instruction assembly with 2-deep queue; HLT detect under `IR_HLT_DETECT_EN
module instr_fetch_ir #(
  parameter int QDEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_ir_if.slave bus
);

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  phase_t                   phase_q, phase_d;
  logic [7:0]               hi_byte_q, hi_byte_d;
  logic [QDEPTH-1:0][15:0]  mem_q, mem_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;
  logic                     inc_pc_q, inc_pc_d;

  logic                     halt_w;
  logic                     byte_ready_w;
  logic                     acc;
  logic                     push;
  logic                     pop;
  logic [15:0]              head;

`ifdef IR_HLT_DETECT_EN
  logic halt_q, halt_d;

  // Sticky halt: set by pushing an opcode-000 instruction, cleared only by reset.
  always_comb begin
    halt_d = halt_q | (push & (hi_byte_q[7:5] == 3'b000));
  end

  // Halt flag register.
  always_ff @(posedge clk) begin
    if (reset) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end

  assign halt_w = halt_q;
`else
  assign halt_w = 1'b0;
`endif

  // Ready depends only on registered state and flush, never on instr_ready.
  assign byte_ready_w = ~bus.flush & ~halt_w & ~((phase_q == PH_LO) & (count_q == 2'd2));
  assign acc          = bus.byte_valid & byte_ready_w;
  assign push         = acc & (phase_q == PH_LO);
  assign pop          = (count_q != 2'd0) & bus.instr_ready & ~bus.flush;
  assign head         = mem_q[rd_ptr_q];

  assign bus.byte_ready  = byte_ready_w;
  assign bus.inc_pc      = inc_pc_q;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.opcode      = head[15:13];
  assign bus.addr_ir     = head[12:0];
  assign bus.halt        = halt_w;

  // Next-state: phase FSM, byte latch, queue pointers/count and inc_pc pulse.
  always_comb begin
    phase_d   = phase_q;
    hi_byte_d = hi_byte_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    inc_pc_d  = acc;

    if (bus.flush) begin
      phase_d  = PH_HI;
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (acc) begin
        if (phase_q == PH_HI) begin
          hi_byte_d = bus.byte_in;
          phase_d   = PH_LO;
        end else begin
          mem_d[wr_ptr_q] = {hi_byte_q, bus.byte_in};
          wr_ptr_d        = ~wr_ptr_q;
          phase_d         = PH_HI;
        end
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_HI;
      hi_byte_q <= 8'h00;
      mem_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      inc_pc_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hi_byte_q <= hi_byte_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inc_pc_q  <= inc_pc_d;
    end
  end

endmodule
